// File: rtl/gb_timer_pkg.sv
// Shared constants and types for the Game Boy divider/timer block.
package gb_timer_pkg;

    localparam logic [1:0] OFF_DIV  = 2'd0;
    localparam logic [1:0] OFF_TIMA = 2'd1;
    localparam logic [1:0] OFF_TMA  = 2'd2;
    localparam logic [1:0] OFF_TAC  = 2'd3;

    localparam logic [3:0] TAP_SEL0 = 4'd9;
    localparam logic [3:0] TAP_SEL1 = 4'd3;
    localparam logic [3:0] TAP_SEL2 = 4'd5;
    localparam logic [3:0] TAP_SEL3 = 4'd7;

    localparam logic [1:0] RELOAD_DELAY = 2'd3;

    typedef enum logic {
        COUNT  = 1'b0,
        RELOAD = 1'b1
    } timer_state_t;

    function automatic logic [15:0] reg_addr(input logic [15:0] base, input logic [1:0] offset);
        return base + {14'd0, offset};
    endfunction

    function automatic logic [3:0] tap_index(input logic [1:0] sel);
        logic [3:0] idx;
        unique case (sel)
            2'b00:   idx = TAP_SEL0;
            2'b01:   idx = TAP_SEL1;
            2'b10:   idx = TAP_SEL2;
            default: idx = TAP_SEL3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/gb_timer_tap.sv
// Combinational tap select: picks the divider bit chosen by TAC and gates it with the enable.
module timer_tap
    import gb_timer_pkg::*;
(
    input  logic [15:0] sysctr,
    input  logic [2:0]  tac,
    output logic        tick_sig
);

    logic [3:0] idx;

    assign idx      = tap_index(tac[1:0]);
    assign tick_sig = tac[2] & sysctr[idx];

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer with delayed TMA reload and one-cycle interrupt pulse.
module gb_timer
    import gb_timer_pkg::*;
#(
    parameter logic [15:0] DIV_ADDR = 16'hff04
) (
    input  logic        clockgb,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    output logic        irq
);

    logic [15:0]  sysctr;
    logic [7:0]   tima;
    logic [7:0]   tima_next;
    logic [7:0]   tma;
    logic [7:0]   tima_view;
    logic [2:0]   tac;
    logic [8:0]   tima_inc;
    logic [1:0]   delay;
    logic [1:0]   delay_next;
    logic         tick_sig;
    logic         tick_d;
    logic         tick_fall;
    logic         reload_now;
    timer_state_t state;
    timer_state_t state_next;

    logic hit_div, hit_tima, hit_tma, hit_tac;
    logic wr_div, wr_tima, wr_tma, wr_tac;

    assign hit_div  = (address == reg_addr(DIV_ADDR, OFF_DIV));
    assign hit_tima = (address == reg_addr(DIV_ADDR, OFF_TIMA));
    assign hit_tma  = (address == reg_addr(DIV_ADDR, OFF_TMA));
    assign hit_tac  = (address == reg_addr(DIV_ADDR, OFF_TAC));

    assign wr_div   = store & hit_div;
    assign wr_tima  = store & hit_tima;
    assign wr_tma   = store & hit_tma;
    assign wr_tac   = store & hit_tac;

    timer_tap u_tap (
        .sysctr   (sysctr),
        .tac      (tac),
        .tick_sig (tick_sig)
    );

    // A DIV clear or TAC rewrite that drops tick_sig also counts as a falling edge.
    assign tick_fall  = tick_d & ~tick_sig;
    assign tima_inc   = {1'b0, tima} + 9'd1;
    assign reload_now = (state == RELOAD) && (delay == RELOAD_DELAY);
    assign tima_view  = reload_now ? tma : tima;

    always_ff @(posedge clockgb or posedge reset) begin
        if (reset) begin
            sysctr <= 16'd0;
            tac    <= 3'd0;
            tma    <= 8'd0;
            tick_d <= 1'b0;
        end else begin
            sysctr <= wr_div ? 16'd0 : sysctr + 16'd1;
            tick_d <= tick_sig;
            if (wr_tac) tac <= indata[2:0];
            if (wr_tma) tma <= indata;
        end
    end

    always_ff @(posedge clockgb or posedge reset) begin
        if (reset) begin
            state <= COUNT;
            delay <= 2'd0;
            tima  <= 8'd0;
        end else begin
            state <= state_next;
            delay <= delay_next;
            tima  <= tima_next;
        end
    end

    // TIMA sits at zero through RELOAD; the final delay count raises irq and loads TMA.
    always_comb begin
        state_next = state;
        delay_next = delay;
        tima_next  = tima;
        irq        = 1'b0;
        unique case (state)
            COUNT: begin
                if (wr_tima) begin
                    tima_next = indata;
                end else if (tick_fall) begin
                    tima_next = tima_inc[7:0];
                    if (tima_inc[8]) begin
                        state_next = RELOAD;
                        delay_next = 2'd0;
                    end
                end
            end
            RELOAD: begin
                if (delay == RELOAD_DELAY) begin
                    irq        = 1'b1;
                    tima_next  = wr_tma ? indata : tma;
                    state_next = COUNT;
                    delay_next = 2'd0;
                end else if (wr_tima) begin
                    tima_next  = indata;
                    state_next = COUNT;
                    delay_next = 2'd0;
                end else begin
                    delay_next = delay + 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        outdata = 8'd0;
        if (load) begin
            if (hit_div)       outdata = sysctr[15:8];
            else if (hit_tima) outdata = tima_view;
            else if (hit_tma)  outdata = tma;
            else if (hit_tac)  outdata = {5'b11111, tac};
        end
    end

endmodule
